// File: rtl/multiply_pkg.sv
// multiply_pkg: state type and sizing helpers shared by the shift-add multiplier
package multiply_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int WIDTH_DEFAULT = 8;
    localparam int PROD_WIDTH = 2 * WIDTH_DEFAULT;
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction
    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction
endpackage

// File: rtl/multiply_cond_neg.sv
// multiply_cond_neg: combinational two's-complement negation when neg is set
module multiply_cond_neg #(
    parameter int WIDTH = 8
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    assign dout = neg ? -din : din;
endmodule

// File: rtl/multiply_param.sv
// multiply_param: sequential shift-add multiplier, WIDTH cycles per product
// Signed two's-complement mode is built only when MULTIPLY_SIGNED_EN is defined.
module multiply_param
    import multiply_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = cnt_width(WIDTH);
    localparam int PW = prod_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mag_a, mag_b, mcand_q, mplier_q;
    logic             neg, neg_q, last, accept;
    logic [PW-1:0]    acc, acc_sum, result;
    logic [CW-1:0]    cnt;

`ifdef MULTIPLY_SIGNED_EN
    multiply_cond_neg #(.WIDTH(WIDTH)) u_neg_a (
        .neg(signed_mode & multiplicand[WIDTH-1]), .din(multiplicand), .dout(mag_a));
    multiply_cond_neg #(.WIDTH(WIDTH)) u_neg_b (
        .neg(signed_mode & multiplier[WIDTH-1]), .din(multiplier), .dout(mag_b));
    multiply_cond_neg #(.WIDTH(PW)) u_neg_p (
        .neg(neg_q), .din(acc_sum), .dout(result));
    assign neg = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
    assign mag_a  = multiplicand;
    assign mag_b  = multiplier;
    assign neg    = 1'b0;
    assign result = acc_sum;
`endif

    assign busy    = (state == RUN);
    assign accept  = (state == IDLE) && start;
    assign last    = (cnt == CW'(WIDTH - 1));
    // partial product for the current multiplier bit, weighted by its position
    assign acc_sum = mplier_q[cnt] ? acc + (PW'(mcand_q) << cnt) : acc;

    always_comb begin
        state_nxt = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    end

    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            product  <= '0;
            done     <= 1'b0;
        end else begin
            done <= busy && last;
            if (accept) begin
                mcand_q  <= mag_a;
                mplier_q <= mag_b;
                neg_q    <= neg;
                acc      <= '0;
                cnt      <= '0;
            end else if (busy) begin
                acc <= acc_sum;
                cnt <= cnt + 1'b1;
                if (last)
                    product <= result;
            end
        end
    end
endmodule

// File: tb/tb_multiply_param.sv
// tb_multiply_param: scoreboard bench for 4- and 8-bit multiply_param instances
module tb_multiply_param;
`ifdef MULTIPLY_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start4, sm4, busy4, done4;
    logic [3:0] a4, b4;
    logic [7:0] p4;
    logic       start8, sm8, busy8, done8;
    logic [7:0] a8, b8;
    logic [15:0] p8;

    int tests = 0;
    int errors = 0;
    int cyc = 0;
    int run4 = 0, run8 = 0;
    logic prev_done4 = 1'b0, prev_done8 = 1'b0;
    logic [63:0] q4[$];
    logic [63:0] q8[$];
    int dc8[$];

    multiply_param #(.WIDTH(4)) u4 (
        .clock(clock), .reset_n(reset_n), .start(start4), .multiplicand(a4),
        .multiplier(b4), .signed_mode(sm4), .product(p4), .busy(busy4), .done(done4));
    multiply_param #(.WIDTH(8)) u8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .multiplicand(a8),
        .multiplier(b8), .signed_mode(sm8), .product(p8), .busy(busy8), .done(done8));

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // reference: integer product of the operand values, truncated to 2*w bits
    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b, input logic sm);
        longint sa, sb, p;
        logic [63:0] m;
        m  = (64'd1 << w) - 64'd1;
        sa = longint'(a & m[31:0]);
        sb = longint'(b & m[31:0]);
        if (SIGNED_EN && sm) begin
            if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
            if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        end
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            run4 = 0;
            run8 = 0;
        end else begin
            if (busy4) run4++;
            if (busy8) run8++;
            if (done4) begin
                chk("busy_with_done4", 64'(busy4), 64'd0);
                chk("done_pulse4", 64'(prev_done4), 64'd0);
                chk("busy_len4", 64'(run4), 64'd4);
                run4 = 0;
                if (q4.size() == 0) begin
                    tests++; errors++;
                    $display("FAIL unexpected_done4: got product %0h expected no done", p4);
                end else chk("product4", 64'(p4), q4.pop_front());
            end
            if (done8) begin
                chk("busy_with_done8", 64'(busy8), 64'd0);
                chk("done_pulse8", 64'(prev_done8), 64'd0);
                chk("busy_len8", 64'(run8), 64'd8);
                run8 = 0;
                dc8.push_back(cyc);
                if (q8.size() == 0) begin
                    tests++; errors++;
                    $display("FAIL unexpected_done8: got product %0h expected no done", p8);
                end else chk("product8", 64'(p8), q8.pop_front());
            end
        end
        prev_done4 = done4;
        prev_done8 = done8;
    end

    // call at posedge+1; waits for the target unit to be idle, then issues one request
    task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b, input logic sm);
        int n;
        n = 0;
        while ((w8 ? busy8 : busy4) && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 100) begin
            tests++; errors++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; start8 = 1'b1;
            q8.push_back(model(8, a, b, sm));
        end else begin
            a4 = a[3:0]; b4 = b[3:0]; sm4 = sm; start4 = 1'b1;
            q4.push_back(model(4, a, b, sm));
        end
        @(posedge clock); #1;
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        chk("drain_pending", 64'(q4.size() + q8.size()), 64'd0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy4", 64'(busy4), 64'd0);
        chk("rst_done4", 64'(done4), 64'd0);
        chk("rst_product4", 64'(p4), 64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        chk("rst_product8", 64'(p8), 64'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        run_op(0, 4, 3, 0);
        run_op(0, 15, 15, 0);
        run_op(0, 8, 8, 1);
        run_op(0, 13, 5, 1);
        run_op(0, 7, 0, 1);
        run_op(0, 8, 7, 1);
        run_op(1, 128, 128, 1);
        run_op(1, 128, 127, 1);
        run_op(1, 255, 1, 1);
        run_op(1, 0, 255, 0);
        drain();

        run_op(0, 3, 5, 0);
        @(posedge clock); #1;
        a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
        @(posedge clock); #1;
        start4 = 1'b0;
        drain();
        repeat (6) @(posedge clock);
        #1;

        run_op(0, 6, 7, 0);
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("abort_busy", 64'(busy4), 64'd0);
        chk("abort_done", 64'(done4), 64'd0);
        chk("abort_product", 64'(p4), 64'd0);
        q4.delete();
        reset_n = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        run_op(0, 2, 3, 0);
        drain();

        dc8.delete();
        run_op(1, 200, 100, 0);
        run_op(1, 255, 255, 0);
        drain();
        if (dc8.size() == 2) chk("b2b_spacing", 64'(dc8[1] - dc8[0]), 64'd9);
        else chk("b2b_done_count", 64'(dc8.size()), 64'd2);

        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
